// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state type for the instruction fetch stage
package fetch_pkg;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_NOP_HALT = 4;
    typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/imem_word_reader.sv
// imem_word_reader: big-endian 4-byte word assembly with byte index wrap
module imem_word_reader #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W = $clog2(MEM_BYTES)
) (
    input  logic [7:0]        mem [MEM_BYTES],
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       word
);
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    assign a1 = addr + ADDR_W'(1);
    assign a2 = addr + ADDR_W'(2);
    assign a3 = addr + ADDR_W'(3);
    assign word = {mem[addr], mem[a1], mem[a2], mem[a3]};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, stall/redirect handling and NOP-run halt detection
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NOP_HALT = DEFAULT_NOP_HALT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instruction_mem [MEM_BYTES],
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted,
    output logic        misaligned
);
    fetch_state_t state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        misaligned_q, misaligned_d;
    logic [2:0]  nop_cnt_q, nop_cnt_d;
    logic [31:0] mem_word;

    imem_word_reader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_reader (
        .mem  (instruction_mem),
        .addr (fetch_pc_q[ADDR_W-1:0]),
        .word (mem_word)
    );

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        misaligned_d = misaligned_q;
        nop_cnt_d    = nop_cnt_q;
        if (state_q == RUN) begin
            // A completed NOP run halts on the following edge, ahead of any redirect or stall
            if (nop_cnt_q == 3'(NOP_HALT)) begin
                halted_d = 1'b1;
                valid_d  = 1'b0;
                state_d  = HALT;
            end else if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = redirect_pc;
                valid_d    = 1'b0;
                nop_cnt_d  = 3'd0;
            end else if (redirect_valid) begin
                misaligned_d = 1'b1;
                valid_d      = 1'b0;
                state_d      = HALT;
            end else if (!stall) begin
                instr_d    = mem_word;
                pc_d       = fetch_pc_q;
                valid_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
                nop_cnt_d  = (mem_word != NOP_WORD) ? 3'd0 :
                             (nop_cnt_q == 3'd7)    ? 3'd7 : nop_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            fetch_pc_q   <= '0;
            instr_q      <= '0;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
            nop_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
            nop_cnt_q    <= nop_cnt_d;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign valid       = valid_q;
    assign halted      = halted_q;
    assign misaligned  = misaligned_q;
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the MIPS core. It reads the byte-addressed, big-endian instruction memory array written by the program loader or bench, and maintains the PC. It presents one registered 32-bit instruction per cycle to decode, with stall and redirect (branch/jump) inputs. It also detects end-of-program: a run of consecutive NOP words is the halt condition.

## Interface
- MEM_BYTES, 256, instruction memory size in bytes (power of two)
- ADDR_W, 8, log2(MEM_BYTES); byte index width
- NOP_HALT, 4, consecutive issued NOPs that trigger halt (1..7)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- instruction_mem  in  [7:0] x MEM_BYTES  unpacked byte array; byte 0 = MSB of word 0
- stall  in  1  hold PC and outputs this cycle
- redirect_valid  in  1  load redirect_pc as next fetch address
- redirect_pc  in  32  branch/jump target (byte address)
- instruction  out  32  fetched word
- pc  out  32  byte address of `instruction`
- pc_plus4  out  32  pc + 4, for link/branch arithmetic
- valid  out  1  `instruction` is a live issue this cycle
- halted  out  1  sticky end-of-program flag
- misaligned  out  1  sticky; a redirect target had pc[1:0] != 0

## Operation
- Internal fetch_pc (32 b). Word read is {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with a = fetch_pc[ADDR_W-1:0] and each byte index computed mod MEM_BYTES (wraps past the top byte).
- The PC is 32 b and increments by 4 without truncation. Only the low ADDR_W bits address memory.
- States:
  - RUN: normal fetch.
  - HALT: absorbing until reset.
- Per edge in RUN, in priority order reset > redirect > stall > sequential:
  - redirect_valid with redirect_pc[1:0] == 0: fetch_pc <= redirect_pc; valid <= 0 (bubble); NOP count <= 0; outputs otherwise hold.
  - redirect_valid with redirect_pc[1:0] != 0: misaligned <= 1; go to HALT.
  - stall (no redirect): all registers hold, valid included.
  - Otherwise (sequential): instruction <= word(fetch_pc); pc <= fetch_pc; valid <= 1; fetch_pc <= fetch_pc + 4.
- NOP count is a 3-bit saturating counter.
  - Increments on each sequential issue of 32'h0000_0000; clears on any non-zero issue.
  - The edge after the issue that brings the count to NOP_HALT sets halted = 1, valid = 0 and enters HALT.
- HALT: fetch_pc, instruction and pc freeze; valid = 0. stall and redirect are ignored.
- pc_plus4 = pc + 4, combinational from the pc register.

## Timing
- Reset values: fetch_pc = 0, instruction = 0, pc = 0, valid = 0, halted = 0, misaligned = 0, NOP count = 0, state RUN.
- Latency:
  - First edge after reset deasserts: instruction = word@0, pc = 0, valid = 1.
  - One new word per unstalled cycle.
  - Redirect costs one bubble cycle; the target word appears on the following edge.
- Stall and redirect in the same cycle: redirect wins.
- Reset mid-run or in HALT returns to reset values on the next edge, regardless of other inputs.
- Memory contents are sampled at the edge. A change to instruction_mem is visible at the next fetch only, never retroactively.

## Structure
- Shared package fetch_pkg holds:
  - NOP_WORD = 32'h0
  - typedef enum {RUN, HALT} fetch_state_t
  - default NOP_HALT and ADDR_W constants
- Sub-module imem_word_reader: combinational big-endian 4-byte assembly with modulo index wrap, parameterised by MEM_BYTES. It is reused later by the data-memory load path.

## Test plan
- Sequential fetch:
  - Stimulus: mem[0..7] = 20 0a 00 0a 20 0c 00 0b, reset released.
  - Required: edge 1 gives instruction 200a000a, pc 0, valid 1; edge 2 gives 200c000b, pc 4, pc_plus4 8.
- NOP run below threshold:
  - Stimulus: 3 NOPs at 8..19, then 018a5820 at 20.
  - Required: no halt; 018a5820 issues with pc 20.
- Halt:
  - Stimulus: 4 NOPs from 0x2c onward.
  - Required: 4th NOP issues with valid 1; next edge gives halted 1, valid 0, pc held at 0x38; remains so for 10 cycles under toggling stall/redirect.
- Stall then redirect:
  - Stimulus: stall held 3 cycles at pc 4.
  - Required: outputs unchanged for those 3 cycles.
  - Stimulus: then redirect_pc = 0x34 together with stall.
  - Required: one edge with valid 0, then instruction = word@0x34, pc 0x34.
- Misaligned and wrap:
  - Stimulus: redirect_pc = 0x6.
  - Required: misaligned 1, halted 0, valid 0, frozen.
  - Stimulus: separately, redirect to 0xFC with mem[252..255] = 8d 50 00 00.
  - Required: 8d500000 issues, then next pc = 0x100 reads bytes 0..3.
- Reset mid-operation:
  - Stimulus: reset asserted in HALT and in RUN at pc 0x20.
  - Required: all outputs return to zero; first post-reset issue is word@0.
